vga_sync_timing_receiver: RTL

- Receive end of the VGA sync interface; the controller's counters drive hsync/vsync, and this block measures them.
- Samples incoming hsync/vsync on pixel ticks.
- Recovers pixel_x/line_y, measures line length, hsync pulse width and lines per frame.
- Declares lock after consecutive identical frames; used for self-check loopback and external-source mode detection.

---
 rtl/vga_sync_timing_receiver.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_timing_receiver.sv
// Receive side of the VGA sync interface: recovers pixel/line position, measures line, hsync and
// frame timing, and declares lock. Define SYNC_POLARITY_DETECT_EN to auto-detect sync polarity.
module vga_sync_timing_receiver #(
  parameter int unsigned COUNTER_SIZE      = 11,
  parameter int unsigned LINE_COUNTER_SIZE = 11,
  parameter int unsigned LOCK_FRAMES       = 2,
  parameter bit          SYNC_ACTIVE_LOW   = 1'b1
) (
  input  logic                         control_clock,
  input  logic                         control_reset_n,
  input  logic                         counter_enable,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  output logic [COUNTER_SIZE-1:0]      pixel_x,
  output logic [LINE_COUNTER_SIZE-1:0] line_y,
  output logic [COUNTER_SIZE-1:0]      line_length,
  output logic [COUNTER_SIZE-1:0]      hsync_width,
  output logic [LINE_COUNTER_SIZE-1:0] frame_lines,
  output logic                         frame_start,
`ifdef SYNC_POLARITY_DETECT_EN
  output logic                         sync_polarity_low,
`endif
  output logic                         locked
);

  localparam int unsigned CW = COUNTER_SIZE;
  localparam int unsigned LW = LINE_COUNTER_SIZE;
  localparam logic [CW-1:0] PixMax  = {CW{1'b1}};
  localparam logic [CW-1:0] PixOne  = CW'(1);
  localparam logic [LW-1:0] LineMax = {LW{1'b1}};
  localparam logic [LW-1:0] LineOne = LW'(1);

  typedef enum logic [1:0] {StSearch, StMeasure, StVerify, StLocked} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   pixel_x_q, pixel_x_d, hw_cnt_q, hw_cnt_d, hsync_width_q, hsync_width_d;
  logic [CW-1:0]   line_length_q, line_length_d, meas_len;
  logic [LW-1:0]   line_y_q, line_y_d, frame_lines_q, frame_lines_d, meas_lines;
  logic            hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic            frame_start_q, locked_q, got_len_q, got_len_d;
  logic [3:0]      match_q, match_d;
  logic [1:0]      pol_low, pol_low_d;  // bit 0 hsync, bit 1 vsync; 1 = active low
  logic            pol_ready;
  logic            hs_act, vs_act, hs_edge, hs_fall, vs_edge, timeout, mismatch;

  assign hs_act   = hsync_in ^ pol_low[0];
  assign vs_act   = vsync_in ^ pol_low[1];
  assign hs_edge  = counter_enable & hs_act & ~hs_prev_q;
  assign hs_fall  = counter_enable & ~hs_act & hs_prev_q;
  assign vs_edge  = counter_enable & vs_act & ~vs_prev_q;
  assign meas_len   = pixel_x_q + PixOne;
  assign meas_lines = line_y_q + LineOne;
  // A saturated counter with no resetting edge means the sync has gone away.
  assign timeout  = counter_enable & (((pixel_x_q == PixMax) & ~hs_edge) |
                                      ((line_y_q == LineMax) & ~vs_edge));
  assign mismatch = (hs_edge & (meas_len != line_length_q)) |
                    (vs_edge & (meas_lines != frame_lines_q));

`ifdef SYNC_POLARITY_DETECT_EN
  localparam int unsigned DW = CW + LW;
  logic [1:0][DW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [1:0]         seen_q, seen_d, pol_ok_q, pol_ok_d, pol_q, raw, raw_prev;

  assign raw      = {vsync_in, hsync_in};
  assign raw_prev = {vs_prev_q, hs_prev_q} ^ pol_q;

  // Over one raw rising-to-rising period, the shorter level is the active one.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    seen_d    = seen_q;
    pol_ok_d  = pol_ok_q;
    pol_low_d = pol_q;
    for (int i = 0; i < 2; i++) begin
      if (state_q != StSearch) begin
        seen_d[i]   = 1'b0;
        pol_ok_d[i] = 1'b0;
      end else if (counter_enable) begin
        if (raw[i] & ~raw_prev[i]) begin
          if (seen_q[i]) begin
            pol_low_d[i] = lo_q[i] < hi_q[i];
            pol_ok_d[i]  = 1'b1;
          end
          seen_d[i] = 1'b1;
          hi_d[i]   = DW'(1);
          lo_d[i]   = '0;
        end else if (raw[i]) begin
          if (hi_q[i] != {DW{1'b1}}) hi_d[i] = hi_q[i] + DW'(1);
        end else if (lo_q[i] != {DW{1'b1}}) begin
          lo_d[i] = lo_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge control_clock) begin
    if (!control_reset_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      seen_q   <= '0;
      pol_ok_q <= '0;
      pol_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      seen_q   <= seen_d;
      pol_ok_q <= pol_ok_d;
      pol_q    <= pol_low_d;
    end
  end

  assign pol_low           = pol_q;
  assign pol_ready         = &pol_ok_q;
  assign sync_polarity_low = pol_q[0];
`else
  assign pol_low   = {2{SYNC_ACTIVE_LOW}};
  assign pol_low_d = pol_low;
  assign pol_ready = 1'b1;
`endif

  always_comb begin
    pixel_x_d     = pixel_x_q;
    line_y_d      = line_y_q;
    hw_cnt_d      = hw_cnt_q;
    hsync_width_d = hsync_width_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    if (counter_enable) begin
      if (hs_edge) pixel_x_d = '0;
      else if (pixel_x_q != PixMax) pixel_x_d = pixel_x_q + PixOne;
      if (vs_edge) line_y_d = '0;
      else if (hs_edge && (line_y_q != LineMax)) line_y_d = line_y_q + LineOne;
      if (hs_edge) hw_cnt_d = PixOne;
      else if (hs_act && (hw_cnt_q != PixMax)) hw_cnt_d = hw_cnt_q + PixOne;
      if (hs_fall) hsync_width_d = hw_cnt_q;
      // History is stored normalised to the polarity in force after this tick.
      hs_prev_d = hsync_in ^ pol_low_d[0];
      vs_prev_d = vsync_in ^ pol_low_d[1];
    end
  end

  always_comb begin
    state_d       = state_q;
    line_length_d = line_length_q;
    frame_lines_d = frame_lines_q;
    match_d       = match_q;
    got_len_d     = got_len_q;
    unique case (state_q)
      StSearch: begin
        if (vs_edge && pol_ready) begin
          state_d   = StMeasure;
          got_len_d = 1'b0;
        end
      end
      StMeasure: begin
        if (timeout) begin
          state_d       = StSearch;
          line_length_d = '0;
          frame_lines_d = '0;
        end else begin
          if (hs_edge && !got_len_q) begin
            line_length_d = meas_len;
            got_len_d     = 1'b1;
          end
          if (vs_edge) begin
            if (got_len_q) begin
              frame_lines_d = meas_lines;
              match_d       = '0;
              state_d       = StVerify;
            end else begin
              got_len_d = 1'b0;
            end
          end
        end
      end
      StVerify, StLocked: begin
        if (timeout || mismatch) begin
          state_d       = StSearch;
          line_length_d = '0;
          frame_lines_d = '0;
        end else if (vs_edge && (state_q == StVerify)) begin
          match_d = match_q + 4'd1;
          if (match_d == 4'(LOCK_FRAMES)) state_d = StLocked;
        end
      end
    endcase
  end

  always_ff @(posedge control_clock) begin
    if (!control_reset_n) begin
      state_q       <= StSearch;
      pixel_x_q     <= '0;
      line_y_q      <= '0;
      hw_cnt_q      <= '0;
      hsync_width_q <= '0;
      line_length_q <= '0;
      frame_lines_q <= '0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      match_q       <= '0;
      got_len_q     <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pixel_x_q     <= pixel_x_d;
      line_y_q      <= line_y_d;
      hw_cnt_q      <= hw_cnt_d;
      hsync_width_q <= hsync_width_d;
      line_length_q <= line_length_d;
      frame_lines_q <= frame_lines_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      match_q       <= match_d;
      got_len_q     <= got_len_d;
      frame_start_q <= vs_edge;
      locked_q      <= (state_d == StLocked);
    end
  end

  assign pixel_x     = pixel_x_q;
  assign line_y      = line_y_q;
  assign line_length = line_length_q;
  assign hsync_width = hsync_width_q;
  assign frame_lines = frame_lines_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;

endmodule
